// File: rtl/pointwise_sched_if.sv
// Request/response handshake bundle between requesters and the pointwise scheduler.
// Requester i owns bit i of each vector and bits [16i+15:16i] of the data buses.
interface pointwise_sched_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [16*NREQ-1:0] req_data;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ-1:0]    rsp_ready;
  logic [16*NREQ-1:0] rsp_data;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/pointwise_sched.sv
// Round-robin scheduler sharing one fixed-latency 16-bit datapath among NREQ requesters,
// with credit-based response FIFOs so a result can never arrive at a full FIFO.
module pointwise_sched #(
  parameter int NREQ      = 4,
  parameter int LAT       = 2,
  parameter int RSP_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  pointwise_sched_if.slave    bus,
  output logic [15:0]         dp_in,
  input  logic [15:0]         dp_out
);
  localparam int AW = $clog2(RSP_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]  ptr_q, ptr_d;
  logic [LAT-1:0] tag_vld_q, tag_vld_d;
  logic [IW-1:0]  tag_id_q [LAT];
  logic [IW-1:0]  tag_id_d [LAT];
  logic [CW-1:0]  occ_q [NREQ];
  logic [CW-1:0]  occ_d [NREQ];
  logic [CW-1:0]  infl_q [NREQ];
  logic [CW-1:0]  infl_d [NREQ];
  logic [AW-1:0]  wr_q [NREQ];
  logic [AW-1:0]  wr_d [NREQ];
  logic [AW-1:0]  rd_q [NREQ];
  logic [AW-1:0]  rd_d [NREQ];
  logic [15:0]    mem_q [NREQ][RSP_DEPTH];
  logic [15:0]    mem_d [NREQ][RSP_DEPTH];

  logic [NREQ-1:0] elig, gnt, push, pop;
  logic            gnt_vld, wb_vld;
  logic [IW-1:0]   gnt_id, wb_id;

  // Arbitration: credit = FIFO occupancy plus results still in the datapath.
  always_comb begin
    elig    = '0;
    gnt     = '0;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    dp_in   = 16'h0000;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = bus.req_valid[i] &&
                (({1'b0, occ_q[i]} + {1'b0, infl_q[i]}) < (CW+1)'(RSP_DEPTH));
    end
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (int'(ptr_q) + k) % NREQ;
      if (!gnt_vld && !rst && elig[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = IW'(idx);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_vld && gnt_id == IW'(i)) begin
        gnt[i] = 1'b1;
        dp_in  = bus.req_data[16*i +: 16];
      end
    end
    bus.req_ready = gnt;
  end

  // Write-back side and FIFO heads.
  always_comb begin
    wb_vld = tag_vld_q[LAT-1];
    wb_id  = tag_id_q[LAT-1];
    for (int i = 0; i < NREQ; i++) begin
      bus.rsp_valid[i]          = (occ_q[i] != '0);
      bus.rsp_data[16*i +: 16]  = mem_q[i][rd_q[i]];
      push[i]                   = wb_vld && (wb_id == IW'(i));
      pop[i]                    = bus.rsp_valid[i] && bus.rsp_ready[i];
    end
  end

  always_comb begin
    ptr_d     = ptr_q;
    tag_vld_d = tag_vld_q;
    tag_id_d  = tag_id_q;
    mem_d     = mem_q;
    if (gnt_vld) ptr_d = (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;
    tag_vld_d[0] = gnt_vld;
    tag_id_d[0]  = gnt_id;
    for (int s = 1; s < LAT; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_id_d[s]  = tag_id_q[s-1];
    end
    for (int i = 0; i < NREQ; i++) begin
      occ_d[i]  = occ_q[i] + CW'(push[i]) - CW'(pop[i]);
      infl_d[i] = infl_q[i] + CW'(gnt[i]) - CW'(push[i]);
      wr_d[i]   = wr_q[i] + AW'(push[i]);
      rd_d[i]   = rd_q[i] + AW'(pop[i]);
      if (push[i]) mem_d[i][wr_q[i]] = dp_out;
    end
  end

  always_ff @(posedge clk) begin
    tag_id_q <= tag_id_d;
    if (rst) begin
      ptr_q     <= '0;
      tag_vld_q <= '0;
      for (int i = 0; i < NREQ; i++) begin
        occ_q[i]  <= '0;
        infl_q[i] <= '0;
        wr_q[i]   <= '0;
        rd_q[i]   <= '0;
        for (int j = 0; j < RSP_DEPTH; j++) mem_q[i][j] <= 16'h0000;
      end
    end else begin
      ptr_q     <= ptr_d;
      tag_vld_q <= tag_vld_d;
      occ_q     <= occ_d;
      infl_q    <= infl_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      mem_q     <= mem_d;
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_ovf_chk
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push[g] && !pop[g] && occ_q[g] == CW'(RSP_DEPTH)));
  end
endmodule

// File: tb/tb_pointwise_sched.sv
// Scoreboard bench for pointwise_sched with an x+1, two-cycle datapath stub.
module tb_pointwise_sched;
  localparam int NREQ = 4;
  localparam int LAT  = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] dp_in, dp_out;
  logic [15:0] dp_r1 = 16'h0, dp_r2 = 16'h0;

  pointwise_sched_if #(.NREQ(NREQ)) bus ();

  pointwise_sched #(.NREQ(NREQ), .LAT(LAT), .RSP_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .dp_in (dp_in),
    .dp_out(dp_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    dp_r1 <= dp_in + 16'd1;
    dp_r2 <= dp_r1;
  end
  assign dp_out = dp_r2;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] sq [NREQ][$];

  logic [NREQ-1:0]    rdy_s, vld_s;
  logic [15:0]        dpin_s;
  logic [16*NREQ-1:0] rspd_s;

  function automatic void chk(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Scoreboard: push expected result at request handshake, compare at response pop.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) sq[i].delete();
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i])
          sq[i].push_back(bus.req_data[16*i +: 16] + 16'd1);
        if (bus.rsp_valid[i] && bus.rsp_ready[i]) begin
          if (sq[i].size() == 0) chk($sformatf("rsp%0d_unexpected", i), 1, 0);
          else chk($sformatf("rsp%0d_data", i), int'(bus.rsp_data[16*i +: 16]), int'(sq[i].pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle: snapshot outputs mid-cycle, then advance data of granted requesters.
  task automatic cyc();
    @(negedge clk);
    rdy_s  = bus.req_ready;
    vld_s  = bus.rsp_valid;
    dpin_s = dp_in;
    rspd_s = bus.rsp_data;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (rdy_s[i]) bus.req_data[16*i +: 16] = bus.req_data[16*i +: 16] + 16'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    bus.req_data  = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n0, n1, n2;
    logic [15:0] exp_d;
    bus.req_valid = '1;
    bus.rsp_ready = '0;
    bus.req_data  = '0;
    rst = 1'b1;
    cyc();
    cyc();
    chk("reset_req_ready", rdy_s, 0);
    chk("reset_rsp_valid", vld_s, 0);
    chk("reset_rsp_data", (rspd_s != '0) ? 1 : 0, 0);
    chk("reset_dp_in", dpin_s, 0);
    do_reset();

    // Single request on requester 0.
    bus.rsp_ready = '1;
    bus.req_data[15:0] = 16'h0010;
    bus.req_valid = 4'b0001;
    cyc();
    chk("single_grant", rdy_s, 4'b0001);
    bus.req_valid = '0;
    cyc();
    chk("single_t1_valid", vld_s, 0);
    cyc();
    chk("single_t2_valid", vld_s, 0);
    cyc();
    chk("single_t3_valid", vld_s, 4'b0001);
    chk("single_t3_data", int'(rspd_s[15:0]), 16'h0011);
    tick();

    // All four requesters continuously valid.
    do_reset();
    bus.rsp_ready = '1;
    for (int i = 0; i < NREQ; i++) bus.req_data[16*i +: 16] = 16'h0100 * 16'(i + 1);
    bus.req_valid = '1;
    for (int k = 0; k < 12; k++) begin
      exp_d = bus.req_data[16*(k%4) +: 16];
      cyc();
      chk($sformatf("rr_grant_%0d", k), rdy_s, 1 << (k % 4));
      chk($sformatf("rr_dp_in_%0d", k), dpin_s, exp_d);
    end
    bus.req_valid = '0;
    for (int k = 0; k < 6; k++) tick();

    // Requester 2 stalled by its consumer; requester 0 keeps flowing.
    do_reset();
    bus.rsp_ready = 4'b1011;
    bus.req_data[15:0]  = 16'h2000;
    bus.req_data[47:32] = 16'h3000;
    bus.req_valid = 4'b0101;
    n0 = 0;
    n2 = 0;
    for (int k = 0; k < 16; k++) begin
      cyc();
      if (rdy_s[0]) n0++;
      if (rdy_s[2]) n2++;
    end
    chk("burst_grants_req2", n2, 4);
    chk("burst_grants_req0", n0, 12);
    cyc();
    chk("burst_blocked_ready2", rdy_s[2], 0);
    chk("burst_full_valid2", vld_s[2], 1);
    bus.rsp_ready[2] = 1'b1;
    cyc();
    bus.rsp_ready[2] = 1'b0;
    cyc();
    chk("burst_regrant_ready2", rdy_s[2], 1);
    cyc();
    chk("burst_reblock_ready2", rdy_s[2], 0);
    bus.req_valid = '0;
    bus.rsp_ready = '1;
    for (int k = 0; k < 10; k++) tick();

    // Requester 1 at full credit: pop coinciding with a write-back.
    do_reset();
    bus.rsp_ready = 4'b1101;
    bus.req_data[31:16] = 16'h4000;
    bus.req_valid = 4'b0010;
    n1 = 0;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (rdy_s[1]) n1++;
    end
    chk("full_grants_req1", n1, 4);
    bus.rsp_ready[1] = 1'b1;
    cyc();
    chk("full_blocked_ready1", rdy_s[1], 0);
    bus.rsp_ready[1] = 1'b0;
    cyc();
    chk("full_credit_ready1", rdy_s[1], 1);
    cyc();
    bus.rsp_ready[1] = 1'b1;
    cyc();
    chk("full_inflight_ready1", rdy_s[1], 0);
    bus.rsp_ready[1] = 1'b0;
    cyc();
    chk("full_after_wb_ready1", rdy_s[1], 1);
    chk("full_after_wb_valid1", vld_s[1], 1);
    bus.req_valid = '0;
    bus.rsp_ready = '1;
    for (int k = 0; k < 10; k++) tick();
    chk("full_drained_q1", sq[1].size(), 0);

    // Reset while two results are in flight.
    do_reset();
    bus.rsp_ready = '1;
    bus.req_valid = '1;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    chk("midrst_ready_forced", rdy_s, 0);
    rst = 1'b0;
    bus.req_valid = '0;
    for (int k = 0; k < LAT + 2; k++) begin
      cyc();
      chk($sformatf("midrst_no_rsp_%0d", k), vld_s, 0);
    end
    bus.req_valid = '1;
    cyc();
    chk("midrst_ptr_restart", rdy_s, 4'b0001);
    bus.req_valid = '0;
    for (int k = 0; k < 6; k++) tick();

    // Random traffic.
    do_reset();
    for (int k = 0; k < 10000; k++) begin
      bus.req_valid = NREQ'($urandom);
      bus.rsp_ready = NREQ'($urandom);
      bus.req_data  = {$urandom, $urandom};
      tick();
    end
    bus.req_valid = '0;
    bus.rsp_ready = '1;
    for (int k = 0; k < 12; k++) tick();
    for (int i = 0; i < NREQ; i++) chk($sformatf("rand_drained_q%0d", i), sq[i].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
